// File: rtl/store_buffer.sv
// Committed-store queue between the ROB commit port and the data cache write port.
// Optional store-to-load forwarding is built when SB_STORE_FWD_EN is defined.
module store_buffer #(
   parameter int unsigned SB_DEPTH = 4,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              rob_commit,
   input  logic              rob_commitmemwrite,
   input  logic [ADDR_W-1:0] rob_swaddr,
   input  logic [5:0]        rob_commitcurrphyaddr,
   output logic [5:0]        sb_prf_rdaddr,
   input  logic [DATA_W-1:0] prf_sb_rddata,
   output logic              sb_full,
   output logic              sb_empty,
   output logic              dcache_wr_req,
   output logic [ADDR_W-1:0] dcache_wr_addr,
   output logic [DATA_W-1:0] dcache_wr_data,
   input  logic              dcache_wr_ack,
   input  logic [ADDR_W-1:0] ld_addr,
   output logic              sb_fwd_hit,
   output logic [DATA_W-1:0] sb_fwd_data,
   output logic              sb_overflow_err
);

   localparam int unsigned PtrW = $clog2(SB_DEPTH);
   typedef logic [PtrW:0] ptr_t;
   localparam ptr_t PtrOne   = ptr_t'(1);
   localparam ptr_t DepthCnt = ptr_t'(SB_DEPTH);

   ptr_t                wr_ptr_q, wr_ptr_d;
   ptr_t                rd_ptr_q, rd_ptr_d;
   ptr_t                count;
   logic [SB_DEPTH-1:0] valid_q, valid_d;
   logic [ADDR_W-1:0]   addr_q [SB_DEPTH];
   logic [ADDR_W-1:0]   addr_d [SB_DEPTH];
   logic [DATA_W-1:0]   data_q [SB_DEPTH];
   logic [DATA_W-1:0]   data_d [SB_DEPTH];
   logic                overflow_q, overflow_d;
   logic                enq;
   logic                deq;

   assign sb_prf_rdaddr   = rob_commitcurrphyaddr;

   // Occupancy comes only from registered pointers; the wrap bit separates full from empty.
   assign count           = wr_ptr_q - rd_ptr_q;
   assign sb_full         = (count == DepthCnt);
   assign sb_empty        = (count == '0);

   assign enq             = rob_commit & rob_commitmemwrite;
   assign dcache_wr_req   = ~sb_empty;
   assign deq             = dcache_wr_req & dcache_wr_ack;
   assign dcache_wr_addr  = addr_q[rd_ptr_q[PtrW-1:0]];
   assign dcache_wr_data  = data_q[rd_ptr_q[PtrW-1:0]];
   assign sb_overflow_err = overflow_q;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      valid_d    = valid_q;
      addr_d     = addr_q;
      data_d     = data_q;
      overflow_d = overflow_q;

      if (enq) begin
         if (sb_full) begin
            overflow_d = 1'b1;
         end else begin
            addr_d[wr_ptr_q[PtrW-1:0]]  = rob_swaddr;
            data_d[wr_ptr_q[PtrW-1:0]]  = prf_sb_rddata;
            valid_d[wr_ptr_q[PtrW-1:0]] = 1'b1;
            wr_ptr_d                    = wr_ptr_q + PtrOne;
         end
      end

      // Enqueue and dequeue slots differ unless empty (no deq) or full (no enq).
      if (deq) begin
         valid_d[rd_ptr_q[PtrW-1:0]] = 1'b0;
         rd_ptr_d                    = rd_ptr_q + PtrOne;
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         valid_q    <= '0;
         overflow_q <= 1'b0;
         for (int i = 0; i < SB_DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         valid_q    <= valid_d;
         overflow_q <= overflow_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
      end
   end

`ifdef SB_STORE_FWD_EN
   logic [PtrW-1:0] fwd_idx;

   // Walk oldest to youngest so the last match left standing is the youngest store.
   always_comb begin
      sb_fwd_hit  = 1'b0;
      sb_fwd_data = '0;
      fwd_idx     = '0;
      for (int unsigned i = 0; i < SB_DEPTH; i++) begin
         fwd_idx = rd_ptr_q[PtrW-1:0] + PtrW'(i);
         if (valid_q[fwd_idx] && (addr_q[fwd_idx][ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
            sb_fwd_hit  = 1'b1;
            sb_fwd_data = data_q[fwd_idx];
         end
      end
   end
`else
   logic unused_fwd;

   assign sb_fwd_hit  = 1'b0;
   assign sb_fwd_data = '0;
   assign unused_fwd  = ^{ld_addr, valid_q};
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios followed by random traffic,
// all compared against a queue-based model of the committed-store FIFO.
module tb_store_buffer;

   localparam int unsigned Depth = 4;

   logic        clk;
   logic        rst_b;
   logic        rob_commit;
   logic        rob_commitmemwrite;
   logic [31:0] rob_swaddr;
   logic [5:0]  rob_commitcurrphyaddr;
   logic [5:0]  sb_prf_rdaddr;
   logic [31:0] prf_sb_rddata;
   logic        sb_full;
   logic        sb_empty;
   logic        dcache_wr_req;
   logic [31:0] dcache_wr_addr;
   logic [31:0] dcache_wr_data;
   logic        dcache_wr_ack;
   logic [31:0] ld_addr;
   logic        sb_fwd_hit;
   logic [31:0] sb_fwd_data;
   logic        sb_overflow_err;

   logic [31:0] prf [64];
   logic [31:0] qa [$];
   logic [31:0] qd [$];
   logic        m_err;
   int          n_cmp;
   int          n_bad;

   assign prf_sb_rddata = prf[sb_prf_rdaddr];

   store_buffer #(
      .SB_DEPTH(Depth),
      .ADDR_W  (32),
      .DATA_W  (32)
   ) dut (
      .clk                  (clk),
      .rst_b                (rst_b),
      .rob_commit           (rob_commit),
      .rob_commitmemwrite   (rob_commitmemwrite),
      .rob_swaddr           (rob_swaddr),
      .rob_commitcurrphyaddr(rob_commitcurrphyaddr),
      .sb_prf_rdaddr        (sb_prf_rdaddr),
      .prf_sb_rddata        (prf_sb_rddata),
      .sb_full              (sb_full),
      .sb_empty             (sb_empty),
      .dcache_wr_req        (dcache_wr_req),
      .dcache_wr_addr       (dcache_wr_addr),
      .dcache_wr_data       (dcache_wr_data),
      .dcache_wr_ack        (dcache_wr_ack),
      .ld_addr              (ld_addr),
      .sb_fwd_hit           (sb_fwd_hit),
      .sb_fwd_data          (sb_fwd_data),
      .sb_overflow_err      (sb_overflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset();
      chk("rst_req",   64'(dcache_wr_req),   64'(1'b0));
      chk("rst_empty", 64'(sb_empty),        64'(1'b1));
      chk("rst_full",  64'(sb_full),         64'(1'b0));
      chk("rst_err",   64'(sb_overflow_err), 64'(1'b0));
      chk("rst_hit",   64'(sb_fwd_hit),      64'(1'b0));
      chk("rst_fdata", 64'(sb_fwd_data),     64'(32'h0));
   endtask

   // One clock: drive inputs, check outputs mid-cycle against the model, then advance the model.
   task automatic step(input logic c, input logic mw, input logic [31:0] a,
                       input logic [5:0] phy, input logic ack, input logic [31:0] ld);
      logic        m_full;
      logic        m_deq;
      logic        e_hit;
      logic [31:0] e_fd;
      rob_commit            = c;
      rob_commitmemwrite    = mw;
      rob_swaddr            = a;
      rob_commitcurrphyaddr = phy;
      dcache_wr_ack         = ack;
      ld_addr               = ld;
      @(negedge clk);
      m_full = (qa.size() == Depth);
      e_hit  = 1'b0;
      e_fd   = 32'h0;
`ifdef SB_STORE_FWD_EN
      for (int i = qa.size() - 1; i >= 0; i--) begin
         if (qa[i][31:2] == ld[31:2]) begin
            e_hit = 1'b1;
            e_fd  = qd[i];
            break;
         end
      end
`endif
      chk("rdaddr", 64'(sb_prf_rdaddr),   64'(phy));
      chk("full",   64'(sb_full),         64'(m_full));
      chk("empty",  64'(sb_empty),        64'(qa.size() == 0));
      chk("req",    64'(dcache_wr_req),   64'(qa.size() != 0));
      chk("ovf",    64'(sb_overflow_err), 64'(m_err));
      chk("fhit",   64'(sb_fwd_hit),      64'(e_hit));
      chk("fdata",  64'(sb_fwd_data),     64'(e_fd));
      if (qa.size() != 0) begin
         chk("haddr", 64'(dcache_wr_addr), 64'(qa[0]));
         chk("hdata", 64'(dcache_wr_data), 64'(qd[0]));
      end
      m_deq = (qa.size() != 0) && ack;
      if (m_deq) begin
         void'(qa.pop_front());
         void'(qd.pop_front());
      end
      if (c && mw) begin
         if (m_full) begin
            m_err = 1'b1;
         end else begin
            qa.push_back(a);
            qd.push_back(prf[phy]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      m_err = 1'b0;
      for (int i = 0; i < 64; i++) prf[i] = $urandom;
      prf[5]  = 32'hDEADBEEF;
      prf[10] = 32'h11;
      prf[11] = 32'h22;

      rst_b                 = 1'b0;
      rob_commit            = 1'b0;
      rob_commitmemwrite    = 1'b0;
      rob_swaddr            = '0;
      rob_commitcurrphyaddr = '0;
      dcache_wr_ack         = 1'b0;
      ld_addr               = '0;
      #3;
      chk_reset();
      #5;
      rst_b = 1'b1;
      @(posedge clk);
      #1;

      // Single store drained with ack held high.
      step(1'b1, 1'b1, 32'h100, 6'd5, 1'b1, 32'h0);
      step(1'b0, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0);
      step(1'b0, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0);

      // Fill to capacity, then an overflowing fifth store.
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 32'h300 + 32'(i * 4), 6'(20 + i), 1'b0, 32'h300);
      end
      step(1'b1, 1'b1, 32'h3F0, 6'd30, 1'b0, 32'h3F0);
      step(1'b0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h308);

      // Drain every cycle; one store enters right after the first ack.
      step(1'b0, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0);
      step(1'b1, 1'b1, 32'h400, 6'd40, 1'b1, 32'h0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0);

      // Hold two entries, then enqueue and dequeue together.
      step(1'b1, 1'b1, 32'h500, 6'd41, 1'b0, 32'h0);
      step(1'b1, 1'b1, 32'h504, 6'd42, 1'b0, 32'h0);
      step(1'b1, 1'b1, 32'h508, 6'd43, 1'b1, 32'h0);
      step(1'b1, 1'b1, 32'h50C, 6'd44, 1'b1, 32'h0);
      step(1'b0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0);

      // Two stores to the same word; younger one must forward.
      step(1'b1, 1'b1, 32'h200, 6'd10, 1'b0, 32'h202);
      step(1'b1, 1'b1, 32'h200, 6'd11, 1'b0, 32'h202);
      step(1'b0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h202);
      step(1'b0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h204);
      step(1'b0, 1'b0, 32'h0, 6'd0, 1'b1, 32'h200);

      // Asynchronous reset in the middle of a drain, then a late ack.
      dcache_wr_ack = 1'b1;
      #1;
      rst_b = 1'b0;
      #2;
      chk_reset();
      qa.delete();
      qd.delete();
      m_err = 1'b0;
      #4;
      rst_b = 1'b1;
      @(posedge clk);
      #1;
      step(1'b0, 1'b0, 32'h0, 6'd0, 1'b1, 32'h200);
      step(1'b0, 1'b0, 32'h0, 6'd0, 1'b1, 32'h200);

      // Random traffic: a fill-heavy phase then a drain-heavy phase.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
              32'h200 + 32'($urandom_range(0, 15)), 6'($urandom_range(0, 63)),
              (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
              32'h200 + 32'($urandom_range(0, 15)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
